// File: rtl/spi_cache_pkg.sv
// Shared types for the SPI-memory read cache: FSM states, line layout, tag helper.
// Latency/backpressure: n/a (types only).
package spi_cache_pkg;

  localparam int          ADDR_W  = 16;
  localparam int          DATA_W  = 16;
  // Sized for the narrowest possible index so one line type serves any INDEX_W; unused high bits stay zero.
  localparam int          TAG_W   = ADDR_W + 1;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL,
    WRITE,
    RESP
  } cache_state_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cache_line_t;

  // {cs, addr[15:index_w]}, right-aligned in TAG_W bits.
  function automatic logic [TAG_W-1:0] make_tag(input logic cs, input logic [ADDR_W-1:0] addr,
                                                input int index_w);
    logic [TAG_W-1:0] full;
    full = {cs, addr};
    return full >> index_w;
  endfunction

endpackage

// File: rtl/spi_cache_tagram.sv
// Direct-mapped line store: combinational lookup port, fill port, per-line invalidate mask and flush.
// Latency: reads same cycle, writes visible next cycle; no backpressure.
module spi_cache_tagram
  import spi_cache_pkg::*;
#(
  parameter  int INDEX_W = 3,
  localparam int LINES   = 2 ** INDEX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_idx,
  output cache_line_t        rd_line,
  input  logic               fill_vld,
  input  logic [INDEX_W-1:0] fill_idx,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [DATA_W-1:0]  fill_dat,
  input  logic [LINES-1:0]   inv_mask,
  input  logic               flush,
  output logic [LINES-1:0]   valid_view,
  output logic [TAG_W-1:0]   tag_view [LINES]
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  fill_set;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  always_comb begin
    fill_set = '0;
    if (fill_vld) fill_set[fill_idx] = 1'b1;
  end

  // Flush wins over a same-cycle fill so a discarded fill never becomes valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      valid_q <= (valid_q & ~inv_mask) | fill_set;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_vld) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_dat;
    end
  end

  always_comb begin
    rd_line.valid = valid_q[rd_idx];
    rd_line.tag   = tag_q[rd_idx];
    rd_line.data  = data_q[rd_idx];
  end

  assign valid_view = valid_q;
  assign tag_view   = tag_q;

endmodule

// File: rtl/spi_mem_read_cache.sv
// Direct-mapped 16-bit read cache, write-through with +/-1 word overlap invalidation.
// Latency: hit -> up_ready 2 cycles after req sampled; miss/write wait on dn_ready; req/ready handshake both sides.
module spi_mem_read_cache
  import spi_cache_pkg::*;
#(
  parameter int INDEX_W  = 3,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        up_req,
  input  logic        up_we,
  input  logic [15:0] up_addr,
  input  logic [15:0] up_wdata,
  input  logic        up_cs_select,
  output logic [15:0] up_rdata,
  output logic        up_ready,
  output logic        dn_req,
  output logic        dn_we,
  output logic [15:0] dn_addr,
  output logic [15:0] dn_wdata,
  output logic        dn_cs_select,
  input  logic [15:0] dn_rdata,
  input  logic        dn_ready,
  input  logic        flush,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam int LINES = 2 ** INDEX_W;

  cache_state_t      state, state_d;
  logic              dn_req_d;
  logic [15:0]       addr_q, wdata_q;
  logic              we_q, cs_q;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic              fill_vld;
  cache_line_t       rd_line;
  logic [LINES-1:0]  valid_view;
  logic [TAG_W-1:0]  tag_view [LINES];
  logic [LINES-1:0]  inv_mask;
  logic [15:0]       nb_addr [3];

  assign req_tag  = make_tag(cs_q, addr_q, INDEX_W);
  assign hit      = CACHE_EN && rd_line.valid && (rd_line.tag == req_tag);
  assign fill_vld = CACHE_EN && (state == FILL) && dn_ready && !flush;

  assign nb_addr[0] = addr_q - 16'd1;
  assign nb_addr[1] = addr_q;
  assign nb_addr[2] = addr_q + 16'd1;

  // Drop any line holding a word that overlaps the written bytes, on the write's completion edge.
  always_comb begin
    inv_mask = '0;
    if (state == WRITE && dn_ready) begin
      for (int i = 0; i < 3; i++) begin
        if (valid_view[nb_addr[i][INDEX_W-1:0]] &&
            tag_view[nb_addr[i][INDEX_W-1:0]] == make_tag(cs_q, nb_addr[i], INDEX_W))
          inv_mask[nb_addr[i][INDEX_W-1:0]] = 1'b1;
      end
    end
  end

  spi_cache_tagram #(.INDEX_W(INDEX_W)) u_tagram (
    .clk        (clk),
    .reset      (reset),
    .rd_idx     (addr_q[INDEX_W-1:0]),
    .rd_line    (rd_line),
    .fill_vld   (fill_vld),
    .fill_idx   (addr_q[INDEX_W-1:0]),
    .fill_tag   (req_tag),
    .fill_dat   (dn_rdata),
    .inv_mask   (inv_mask),
    .flush      (flush),
    .valid_view (valid_view),
    .tag_view   (tag_view)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    up_ready = 1'b0;
    case (state)
      IDLE:        if (up_req) state_d = up_we ? WRITE : LOOKUP;
      LOOKUP:      state_d = hit ? RESP : FILL;
      FILL, WRITE: if (dn_ready) state_d = RESP;
      RESP: begin
        up_ready = 1'b1;
        state_d  = IDLE;
      end
      default:     state_d = IDLE;
    endcase
    dn_req_d = (state_d == FILL) || (state_d == WRITE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      cs_q     <= 1'b0;
      dn_req   <= 1'b0;
      up_rdata <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      dn_req <= dn_req_d;
      if (state == IDLE && up_req) begin
        addr_q  <= up_addr;
        wdata_q <= up_wdata;
        we_q    <= up_we;
        cs_q    <= up_cs_select;
      end
      if (state == LOOKUP) begin
        if (hit) begin
          up_rdata <= rd_line.data;
          if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + 16'd1;
        end else if (miss_cnt != CNT_MAX) begin
          miss_cnt <= miss_cnt + 16'd1;
        end
      end
      if (state == FILL && dn_ready) up_rdata <= dn_rdata;
    end
  end

  assign dn_we        = we_q;
  assign dn_addr      = addr_q;
  assign dn_wdata     = wdata_q;
  assign dn_cs_select = cs_q;

endmodule

// File: tb/tb_spi_mem_read_cache.sv
// Directed bench for spi_mem_read_cache: hit/miss, conflict, overlap write, cs tag, flush, reset.
module tb_spi_mem_read_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        up_req, up_we, up_cs_select;
  logic [15:0] up_addr, up_wdata, up_rdata;
  logic        up_ready;
  logic        dn_req, dn_we, dn_cs_select;
  logic [15:0] dn_addr, dn_wdata, dn_rdata;
  logic        dn_ready;
  logic        flush;
  logic [15:0] hit_cnt, miss_cnt;

  int checks   = 0;
  int failures = 0;

  logic [15:0] rd, sad, swd;
  logic        swe, scs;
  int          lat, dn;

  always #5 clk = ~clk;

  spi_mem_read_cache #(.INDEX_W(3), .CACHE_EN(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .up_req       (up_req),
    .up_we        (up_we),
    .up_addr      (up_addr),
    .up_wdata     (up_wdata),
    .up_cs_select (up_cs_select),
    .up_rdata     (up_rdata),
    .up_ready     (up_ready),
    .dn_req       (dn_req),
    .dn_we        (dn_we),
    .dn_addr      (dn_addr),
    .dn_wdata     (dn_wdata),
    .dn_cs_select (dn_cs_select),
    .dn_rdata     (dn_rdata),
    .dn_ready     (dn_ready),
    .flush        (flush),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  task automatic do_reset();
    reset = 1'b0; up_req = 1'b0; up_we = 1'b0; up_addr = '0; up_wdata = '0;
    up_cs_select = 1'b0; dn_rdata = '0; dn_ready = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // One full transaction; the downstream side answers in the cycle after dn_req rises.
  task automatic xact(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                      input logic cs, input logic [15:0] dn_dat, input logic flush_at_ready,
                      output logic [15:0] rdata, output int latency, output int dn_count,
                      output logic seen_we, output logic [15:0] seen_addr,
                      output logic [15:0] seen_wdata, output logic seen_cs);
    logic prev;
    bit   done;
    up_req = 1'b1; up_we = we; up_addr = addr; up_wdata = wdata; up_cs_select = cs;
    prev = 1'b0; done = 1'b0; rdata = '0; latency = 0; dn_count = 0;
    seen_we = 1'b0; seen_addr = '0; seen_wdata = '0; seen_cs = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(posedge clk); #1;
      dn_ready = 1'b0; flush = 1'b0;
      if (dn_req && !prev) begin
        dn_count++;
        seen_we = dn_we; seen_addr = dn_addr; seen_wdata = dn_wdata; seen_cs = dn_cs_select;
      end
      prev = dn_req;
      if (dn_req) begin
        dn_ready = 1'b1; dn_rdata = dn_dat; flush = flush_at_ready;
      end
      if (up_ready) begin
        done = 1'b1; latency = cyc; rdata = up_rdata; up_req = 1'b0;
      end
    end
    up_req = 1'b0; dn_ready = 1'b0; flush = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL xact_timeout addr=%h got no up_ready within 40 cycles", addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (up_ready !== 1'b0) begin failures++; $display("FAIL rst_up_ready got=%b exp=0", up_ready); end
    checks++; if (up_rdata !== 16'h0) begin failures++; $display("FAIL rst_up_rdata got=%h exp=0000", up_rdata); end
    checks++; if (dn_req !== 1'b0) begin failures++; $display("FAIL rst_dn_req got=%b exp=0", dn_req); end
    checks++; if ({dn_we, dn_cs_select, dn_addr, dn_wdata} !== 34'h0) begin failures++;
      $display("FAIL rst_dn_fwd got we=%b cs=%b addr=%h wdata=%h exp all zero", dn_we, dn_cs_select, dn_addr, dn_wdata); end
    checks++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin failures++;
      $display("FAIL rst_counters got hit=%0d miss=%0d exp 0/0", hit_cnt, miss_cnt); end
  endtask

  task automatic test_miss_then_hit();
    do_reset();
    xact(1'b0, 16'h0100, 16'h0, 1'b0, 16'hBEEF, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (dn !== 1) begin failures++; $display("FAIL miss_dn_req_count got=%0d exp=1", dn); end
    checks++; if (sad !== 16'h0100 || swe !== 1'b0) begin failures++; $display("FAIL miss_dn_fwd got addr=%h we=%b exp 0100/0", sad, swe); end
    checks++; if (rd !== 16'hBEEF) begin failures++; $display("FAIL miss_rdata got=%h exp=BEEF", rd); end
    checks++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin failures++; $display("FAIL miss_counters got hit=%0d miss=%0d exp 0/1", hit_cnt, miss_cnt); end
    xact(1'b0, 16'h0100, 16'h0, 1'b0, 16'hDEAD, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (dn !== 0) begin failures++; $display("FAIL hit_dn_req_count got=%0d exp=0", dn); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL hit_latency got=%0d exp=2", lat); end
    checks++; if (rd !== 16'hBEEF) begin failures++; $display("FAIL hit_rdata got=%h exp=BEEF", rd); end
    checks++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin failures++; $display("FAIL hit_counters got hit=%0d miss=%0d exp 1/1", hit_cnt, miss_cnt); end
  endtask

  task automatic test_conflict();
    do_reset();
    xact(1'b0, 16'h0100, 16'h0, 1'b0, 16'h1111, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    xact(1'b0, 16'h0108, 16'h0, 1'b0, 16'h2222, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (dn !== 1 || rd !== 16'h2222) begin failures++; $display("FAIL conflict_second got dn=%0d rdata=%h exp 1/2222", dn, rd); end
    xact(1'b0, 16'h0100, 16'h0, 1'b0, 16'h3333, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (dn !== 1 || rd !== 16'h3333) begin failures++; $display("FAIL conflict_third got dn=%0d rdata=%h exp 1/3333", dn, rd); end
    checks++; if (miss_cnt !== 16'd3 || hit_cnt !== 16'd0) begin failures++; $display("FAIL conflict_counters got hit=%0d miss=%0d exp 0/3", hit_cnt, miss_cnt); end
  endtask

  task automatic test_overlap_write();
    do_reset();
    xact(1'b0, 16'h0200, 16'h0, 1'b0, 16'hA000, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    xact(1'b0, 16'h0201, 16'h0, 1'b0, 16'hA001, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    xact(1'b0, 16'h01FF, 16'h0, 1'b0, 16'hA1FF, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    xact(1'b0, 16'h0202, 16'h0, 1'b0, 16'hA002, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    xact(1'b0, 16'h0202, 16'h0, 1'b0, 16'hDEAD, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (dn !== 0 || rd !== 16'hA002) begin failures++; $display("FAIL ovl_prehit got dn=%0d rdata=%h exp 0/A002", dn, rd); end
    xact(1'b1, 16'h0200, 16'h1234, 1'b0, 16'h0, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (dn !== 1 || swe !== 1'b1 || sad !== 16'h0200 || swd !== 16'h1234) begin failures++;
      $display("FAIL ovl_write_fwd got dn=%0d we=%b addr=%h wdata=%h exp 1/1/0200/1234", dn, swe, sad, swd); end
    checks++; if (miss_cnt !== 16'd4 || hit_cnt !== 16'd1) begin failures++; $display("FAIL ovl_write_counters got hit=%0d miss=%0d exp 1/4", hit_cnt, miss_cnt); end
    xact(1'b0, 16'h0200, 16'h0, 1'b0, 16'hB000, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (dn !== 1 || rd !== 16'hB000) begin failures++; $display("FAIL ovl_inv_0200 got dn=%0d rdata=%h exp 1/B000", dn, rd); end
    xact(1'b0, 16'h0201, 16'h0, 1'b0, 16'hB001, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (dn !== 1 || rd !== 16'hB001) begin failures++; $display("FAIL ovl_inv_0201 got dn=%0d rdata=%h exp 1/B001", dn, rd); end
    xact(1'b0, 16'h01FF, 16'h0, 1'b0, 16'hB1FF, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (dn !== 1 || rd !== 16'hB1FF) begin failures++; $display("FAIL ovl_inv_01FF got dn=%0d rdata=%h exp 1/B1FF", dn, rd); end
    xact(1'b0, 16'h0202, 16'h0, 1'b0, 16'hDEAD, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (dn !== 0 || rd !== 16'hA002) begin failures++; $display("FAIL ovl_keep_0202 got dn=%0d rdata=%h exp 0/A002", dn, rd); end
    // Write to 0x0000 must reach back across the wrap to 0xFFFF.
    xact(1'b0, 16'hFFFF, 16'h0, 1'b0, 16'hAFFF, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    xact(1'b0, 16'hFFFF, 16'h0, 1'b0, 16'hDEAD, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (dn !== 0 || rd !== 16'hAFFF) begin failures++; $display("FAIL wrap_prehit got dn=%0d rdata=%h exp 0/AFFF", dn, rd); end
    xact(1'b1, 16'h0000, 16'h5555, 1'b0, 16'h0, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    xact(1'b0, 16'hFFFF, 16'h0, 1'b0, 16'hCFFF, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (dn !== 1 || rd !== 16'hCFFF) begin failures++; $display("FAIL wrap_inv got dn=%0d rdata=%h exp 1/CFFF", dn, rd); end
    xact(1'b1, 16'h0600, 16'h7777, 1'b0, 16'h0, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    xact(1'b0, 16'h0600, 16'h0, 1'b0, 16'h6060, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (dn !== 1 || rd !== 16'h6060) begin failures++; $display("FAIL no_write_alloc got dn=%0d rdata=%h exp 1/6060", dn, rd); end
  endtask

  task automatic test_cs_select();
    do_reset();
    xact(1'b0, 16'h0300, 16'h0, 1'b0, 16'hAAAA, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    xact(1'b0, 16'h0300, 16'h0, 1'b1, 16'hBBBB, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (dn !== 1 || scs !== 1'b1 || rd !== 16'hBBBB) begin failures++;
      $display("FAIL cs_miss got dn=%0d cs=%b rdata=%h exp 1/1/BBBB", dn, scs, rd); end
    checks++; if (miss_cnt !== 16'd2) begin failures++; $display("FAIL cs_miss_cnt got=%0d exp=2", miss_cnt); end
    xact(1'b0, 16'h0300, 16'h0, 1'b1, 16'hDEAD, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (dn !== 0 || rd !== 16'hBBBB) begin failures++; $display("FAIL cs_rehit got dn=%0d rdata=%h exp 0/BBBB", dn, rd); end
  endtask

  task automatic test_flush();
    do_reset();
    xact(1'b0, 16'h0400, 16'h0, 1'b0, 16'h5A5A, 1'b1, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (rd !== 16'h5A5A) begin failures++; $display("FAIL flush_fill_rdata got=%h exp=5A5A", rd); end
    xact(1'b0, 16'h0400, 16'h0, 1'b0, 16'h0F0F, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (dn !== 1 || rd !== 16'h0F0F) begin failures++; $display("FAIL flush_fill_discard got dn=%0d rdata=%h exp 1/0F0F", dn, rd); end
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    checks++; if (miss_cnt !== 16'd2 || hit_cnt !== 16'd0) begin failures++; $display("FAIL flush_counters got hit=%0d miss=%0d exp 0/2", hit_cnt, miss_cnt); end
    xact(1'b0, 16'h0400, 16'h0, 1'b0, 16'h1F1F, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (dn !== 1 || rd !== 16'h1F1F) begin failures++; $display("FAIL flush_idle got dn=%0d rdata=%h exp 1/1F1F", dn, rd); end
  endtask

  task automatic test_reset_mid_fill();
    bit seen;
    do_reset();
    xact(1'b0, 16'h0700, 16'h0, 1'b0, 16'h7070, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    xact(1'b0, 16'h0700, 16'h0, 1'b0, 16'hDEAD, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    up_req = 1'b1; up_we = 1'b0; up_addr = 16'h0100; up_cs_select = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (dn_req) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rmf_fill_start got no dn_req within 10 cycles"); end
    up_req = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    checks++; if (dn_req !== 1'b0 || up_ready !== 1'b0) begin failures++; $display("FAIL rmf_outputs got dn_req=%b up_ready=%b exp 0/0", dn_req, up_ready); end
    checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin failures++; $display("FAIL rmf_counters got hit=%0d miss=%0d exp 0/0", hit_cnt, miss_cnt); end
    @(posedge clk); #1;
    xact(1'b0, 16'h0700, 16'h0, 1'b0, 16'h0707, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (dn !== 1 || rd !== 16'h0707 || miss_cnt !== 16'd1) begin failures++;
      $display("FAIL rmf_refetch got dn=%0d rdata=%h miss=%0d exp 1/0707/1", dn, rd, miss_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    xact(1'b0, 16'h0805, 16'h0, 1'b1, 16'h8585, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (lat !== 3) begin failures++; $display("FAIL b2b_miss_latency got=%0d exp=3", lat); end
    xact(1'b0, 16'h0805, 16'h0, 1'b1, 16'hDEAD, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    xact(1'b0, 16'h0805, 16'h0, 1'b1, 16'hDEAD, 1'b0, rd, lat, dn, swe, sad, swd, scs);
    checks++; if (lat !== 2 || rd !== 16'h8585 || dn !== 0) begin failures++;
      $display("FAIL b2b_hit got lat=%0d rdata=%h dn=%0d exp 2/8585/0", lat, rd, dn); end
    checks++; if (hit_cnt !== 16'd2 || miss_cnt !== 16'd1) begin failures++; $display("FAIL b2b_counters got hit=%0d miss=%0d exp 2/1", hit_cnt, miss_cnt); end
  endtask

  initial begin
    test_reset();
    test_miss_then_hit();
    test_conflict();
    test_overlap_write();
    test_cs_select();
    test_flush();
    test_reset_mid_fill();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_mem_read_cache.md
Name: spi_mem_read_cache

Overview:
- Small direct-mapped read cache between interconnect_hub's SPI-memory engine port and spi_memory_controller.
- Serves repeated 16-bit reads (instruction fetch, stack) without a full SPI transaction.
- Writes are write-through with overlap invalidation.
- Both sides use the hub's existing req/ready handshake, so the block drops into the existing wiring unchanged.

Parameters:
- INDEX_W, 3: line-index width; LINES = 2**INDEX_W entries, each holding one 16-bit word.
- CACHE_EN, 1: 0 = every read treated as a miss; fills suppressed; pure pass-through with identical handshake timing.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset; 0 = reset, sampled on posedge clk.
- up_req  in  1  request from hub; held high until up_ready is seen.
- up_we  in  1  1 = write, 0 = read; valid with up_req.
- up_addr  in  16  byte address; word covers bytes addr and addr+1.
- up_wdata  in  16  write data.
- up_cs_select  in  1  target device select; part of the tag.
- up_rdata  out  16  read data; valid while up_ready=1.
- up_ready  out  1  one-cycle completion pulse.
- dn_req  out  1  request to spi_memory_controller.
- dn_we  out  1  forwarded up_we.
- dn_addr  out  16  forwarded address.
- dn_wdata  out  16  forwarded write data.
- dn_cs_select  out  1  forwarded select.
- dn_rdata  in  16  controller read data; valid with dn_ready.
- dn_ready  in  1  controller completion pulse.
- flush  in  1  one-cycle pulse; invalidates all lines.
- hit_cnt  out  16  read-hit counter; saturates at 0xFFFF.
- miss_cnt  out  16  read-miss counter; saturates at 0xFFFF.

Behaviour:
- Reset, while reset=0 at a clock edge:
  - state IDLE; all valid bits 0.
  - up_ready=0, up_rdata=0, dn_req=0, dn_we=0, dn_addr=0, dn_wdata=0, dn_cs_select=0.
  - hit_cnt=0, miss_cnt=0.
  - Reset mid-transaction abandons it; dn_req is low from the first cycle after the reset edge.
- Line layout:
  - index = addr[INDEX_W-1:0]
  - tag = {cs_select, addr[15:INDEX_W]}
  - Each line holds valid, tag, data[15:0].
- FSM states: IDLE, LOOKUP, FILL, WRITE, RESP.
- IDLE: up_req=1 registers addr, we, wdata and cs_select.
  - up_we=0 -> LOOKUP.
  - up_we=1 -> WRITE.
  - dn_* outputs are driven from these registered values.
- LOOKUP: one cycle.
  - Hit (valid, tag match, CACHE_EN=1): load up_rdata from the line; hit_cnt++ -> RESP. Hit latency: up_ready is 2 cycles after the edge that samples up_req.
  - Miss: miss_cnt++; dn_req=1 -> FILL.
- FILL: hold dn_req=1 until dn_ready=1. On that edge:
  - dn_req=0; up_rdata=dn_rdata.
  - Line written (valid=1) if CACHE_EN=1 -> RESP.
- WRITE: hold dn_req=1, dn_we=1 until dn_ready. On that edge:
  - Invalidate lines for word addresses addr-1, addr and addr+1 (16-bit wrap) whose tag matches -> RESP.
  - The cache never allocates on write.
- RESP: up_ready=1 for exactly one cycle -> IDLE.
  - The requester must deassert up_req on the edge where it samples up_ready=1.
  - up_req during RESP is ignored.
  - up_rdata holds its value until the next load.
- flush:
  - Clears all valid bits on that edge in any state.
  - If flush coincides with a FILL completion, the fill is discarded (line stays invalid), but the data is still returned on up_rdata.
  - Does not affect the FSM or the counters.
- dn_req is registered and never asserted in IDLE, LOOKUP or RESP.
- Back-to-back requests: minimum 1 IDLE cycle between transactions.
- Counters increment only on reads and saturate, with no wrap.

Decomposition:
- Package spi_cache_pkg:
  - state enum cache_state_t.
  - line struct cache_line_t {valid, tag, data}.
  - Constants TAG_W and CNT_MAX = 16'hFFFF.
- Optional sub-module spi_cache_tagram: the line array, with one read/lookup port and one fill/invalidate port. Three invalidate compares are done in the top.

Test Plan:
- Read 0x0100 (dn returns 0xBEEF) -> dn_req seen once; up_rdata=0xBEEF; miss_cnt=1. Reread 0x0100 -> no dn_req; up_ready 2 cycles after req; up_rdata=0xBEEF; hit_cnt=1.
- Conflict: read 0x0100, then 0x0108 (same index, INDEX_W=3), then 0x0100 -> three misses, miss_cnt=3, hit_cnt=0.
- Overlap write: cache 0x0200, 0x0201 and 0x01FF; write 0x0200=0x1234 -> dn write forwarded. All three addresses then miss on reread; 0x0202 remains a hit if cached.
- cs_select: read 0x0300 with cs=0, then 0x0300 with cs=1 -> second is a miss forwarded with dn_cs_select=1.
- flush pulsed on the same edge as dn_ready of a fill of 0x0400=0x5A5A -> up_rdata=0x5A5A; next read of 0x0400 misses.
- Reset (reset=0) held 1 cycle during FILL -> next cycle dn_req=0, up_ready=0, counters=0; a following read of a previously cached address misses.
